// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard: forwarding-select
// encodings and the stage-3 scoreboard control entry.
package hazard_pkg;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   // Stage-3 entry control bits; the destination index travels
   // alongside because its width is set per instance by REG_W.
   typedef struct packed {
      logic valid;
      logic wr_en;
      logic is_load;
   } ex_ctrl_t;

   localparam ex_ctrl_t EX_BUBBLE = '0;

endpackage

// File: rtl/hazard_operand_sel.sv
// Per-operand hazard check: matches the read against stage 3/4 writers,
// picks the forwarding source and raises a stall request.
// Ports: rd_en/rd_idx (read), ex_ctrl/ex_idx (stage 3), wb_wr_en/wb_idx
// (stage 4), fwd_sel, stall_req. Macro: HAZARD_FWD_STAGE4_EN.
module hazard_operand_sel
   import hazard_pkg::*;
#(
   parameter int REG_W = 3
) (
   input  logic             rd_en,
   input  logic [REG_W-1:0] rd_idx,
   input  ex_ctrl_t         ex_ctrl,
   input  logic [REG_W-1:0] ex_idx,
   input  logic             wb_wr_en,
   input  logic [REG_W-1:0] wb_idx,
   output logic [1:0]       fwd_sel,
   output logic             stall_req
);

   logic match_ex;
   logic match_wb;

   always_comb begin
      match_ex  = rd_en & ex_ctrl.valid & ex_ctrl.wr_en
                & (ex_idx == rd_idx);
      match_wb  = rd_en & wb_wr_en & (wb_idx == rd_idx);
      fwd_sel   = FWD_REG;
      stall_req = 1'b0;
      // Stage 3 is the youngest writer, so it shadows stage 4.
      priority case (1'b1)
         match_ex: begin
            if (ex_ctrl.is_load) stall_req = 1'b1;
            else                 fwd_sel   = FWD_EX;
         end
         match_wb: begin
`ifdef HAZARD_FWD_STAGE4_EN
            fwd_sel = FWD_WB;
`else
            // No stage-4 bypass: wait one cycle for the
            // write-through register file.
            stall_req = 1'b1;
`endif
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Two-entry (stage 3 / stage 4) hazard scoreboard with operand
// forwarding select, load-use stall and saturating stall counter.
// Ports: clk, rst_n, id_* decode request, id_ready, flush, fwd_a/b_sel,
// ex_valid/ex_wr_idx, wb_wr_en/wb_wr_idx, stall_cnt, stall_cnt_clr.
// Macro: HAZARD_FWD_STAGE4_EN enables stage-4 forwarding.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_W = 3,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   output logic             id_ready,
   input  logic             id_rda_en,
   input  logic             id_rdb_en,
   input  logic [REG_W-1:0] id_rda_idx,
   input  logic [REG_W-1:0] id_rdb_idx,
   input  logic             id_wr_en,
   input  logic [REG_W-1:0] id_wr_idx,
   input  logic             id_is_load,
   input  logic             flush,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic             ex_valid,
   output logic [REG_W-1:0] ex_wr_idx,
   output logic             wb_wr_en,
   output logic [REG_W-1:0] wb_wr_idx,
   output logic [CNT_W-1:0] stall_cnt,
   input  logic             stall_cnt_clr
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   ex_ctrl_t         ex_q, ex_d;
   logic [REG_W-1:0] ex_idx_q, ex_idx_d;
   logic             wb_wr_en_q, wb_wr_en_d;
   logic [REG_W-1:0] wb_idx_q, wb_idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stall_a, stall_b, stall;

   hazard_operand_sel #(.REG_W(REG_W)) u_op_a (
      .rd_en     (id_rda_en),
      .rd_idx    (id_rda_idx),
      .ex_ctrl   (ex_q),
      .ex_idx    (ex_idx_q),
      .wb_wr_en  (wb_wr_en_q),
      .wb_idx    (wb_idx_q),
      .fwd_sel   (fwd_a_sel),
      .stall_req (stall_a)
   );

   hazard_operand_sel #(.REG_W(REG_W)) u_op_b (
      .rd_en     (id_rdb_en),
      .rd_idx    (id_rdb_idx),
      .ex_ctrl   (ex_q),
      .ex_idx    (ex_idx_q),
      .wb_wr_en  (wb_wr_en_q),
      .wb_idx    (wb_idx_q),
      .fwd_sel   (fwd_b_sel),
      .stall_req (stall_b)
   );

   always_comb begin
      // A flush squashes the decode slot, so it cannot stall.
      stall    = id_valid & (stall_a | stall_b) & ~flush;
      id_ready = ~stall;

      ex_d     = EX_BUBBLE;
      ex_idx_d = '0;
      if (id_valid & id_ready & ~flush) begin
         ex_d.valid   = 1'b1;
         ex_d.wr_en   = id_wr_en;
         ex_d.is_load = id_is_load;
         ex_idx_d     = id_wr_idx;
      end

      wb_wr_en_d = ex_q.valid & ex_q.wr_en;
      wb_idx_d   = ex_idx_q;

      cnt_d = cnt_q;
      if (stall_cnt_clr)
         cnt_d = '0;
      else if (stall && (cnt_q != CNT_MAX))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q       <= EX_BUBBLE;
         ex_idx_q   <= '0;
         wb_wr_en_q <= 1'b0;
         wb_idx_q   <= '0;
         cnt_q      <= '0;
      end else begin
         ex_q       <= ex_d;
         ex_idx_q   <= ex_idx_d;
         wb_wr_en_q <= wb_wr_en_d;
         wb_idx_q   <= wb_idx_d;
         cnt_q      <= cnt_d;
      end
   end

   assign ex_valid  = ex_q.valid;
   assign ex_wr_idx = ex_idx_q;
   assign wb_wr_en  = wb_wr_en_q;
   assign wb_wr_idx = wb_idx_q;
   assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed hazard scenarios
// plus randomized traffic against an instruction-level reference model.
module tb_hazard_scoreboard;

   localparam int REG_W   = 3;
   localparam int CNT_W   = 8;
   localparam int CNT_MAX = 255;
`ifdef HAZARD_FWD_STAGE4_EN
   localparam bit FWD4 = 1'b1;
`else
   localparam bit FWD4 = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             id_valid = 1'b0;
   logic             id_ready;
   logic             id_rda_en = 1'b0, id_rdb_en = 1'b0;
   logic [REG_W-1:0] id_rda_idx = '0, id_rdb_idx = '0;
   logic             id_wr_en = 1'b0;
   logic [REG_W-1:0] id_wr_idx = '0;
   logic             id_is_load = 1'b0;
   logic             flush = 1'b0;
   logic [1:0]       fwd_a_sel, fwd_b_sel;
   logic             ex_valid;
   logic [REG_W-1:0] ex_wr_idx;
   logic             wb_wr_en;
   logic [REG_W-1:0] wb_wr_idx;
   logic [CNT_W-1:0] stall_cnt;
   logic             stall_cnt_clr = 1'b0;

   hazard_scoreboard #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .id_valid      (id_valid),
      .id_ready      (id_ready),
      .id_rda_en     (id_rda_en),
      .id_rdb_en     (id_rdb_en),
      .id_rda_idx    (id_rda_idx),
      .id_rdb_idx    (id_rdb_idx),
      .id_wr_en      (id_wr_en),
      .id_wr_idx     (id_wr_idx),
      .id_is_load    (id_is_load),
      .flush         (flush),
      .fwd_a_sel     (fwd_a_sel),
      .fwd_b_sel     (fwd_b_sel),
      .ex_valid      (ex_valid),
      .ex_wr_idx     (ex_wr_idx),
      .wb_wr_en      (wb_wr_en),
      .wb_wr_idx     (wb_wr_idx),
      .stall_cnt     (stall_cnt),
      .stall_cnt_clr (stall_cnt_clr)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: the instruction sitting in stage 3 and stage 4.
   bit m_ex_v, m_ex_wr, m_ex_ld;
   int m_ex_idx;
   bit m_wb_wr;
   int m_wb_idx;
   int m_cnt;
   bit last_stall;

   function automatic void op_expect(input bit en, input int idx,
                                     output int sel, output bit stl);
      sel = 0;
      stl = 1'b0;
      if (en) begin
         if (m_ex_v && m_ex_wr && m_ex_idx == idx) begin
            if (m_ex_ld) stl = 1'b1;
            else         sel = 1;
         end else if (m_wb_wr && m_wb_idx == idx) begin
            if (FWD4) sel = 2;
            else      stl = 1'b1;
         end
      end
   endfunction

   task automatic model_clear();
      m_ex_v = 0; m_ex_wr = 0; m_ex_ld = 0; m_ex_idx = 0;
      m_wb_wr = 0; m_wb_idx = 0; m_cnt = 0; last_stall = 0;
   endtask

   task automatic drive(input bit v, input bit ae, input int ai,
                        input bit be, input int bi, input bit we,
                        input int wi, input bit ld, input bit fl,
                        input bit clr);
      id_valid      = v;
      id_rda_en     = ae;
      id_rda_idx    = ai[REG_W-1:0];
      id_rdb_en     = be;
      id_rdb_idx    = bi[REG_W-1:0];
      id_wr_en      = we;
      id_wr_idx     = wi[REG_W-1:0];
      id_is_load    = ld;
      flush         = fl;
      stall_cnt_clr = clr;
      #1;
   endtask

   task automatic compare();
      int sa, sb;
      bit ta, tb;
      op_expect(id_rda_en, int'(id_rda_idx), sa, ta);
      op_expect(id_rdb_en, int'(id_rdb_idx), sb, tb);
      last_stall = id_valid && (ta || tb) && !flush;
      chk("id_ready", int'(id_ready), int'(!last_stall));
      chk("fwd_a_sel", int'(fwd_a_sel), sa);
      chk("fwd_b_sel", int'(fwd_b_sel), sb);
      chk("ex_valid", int'(ex_valid), int'(m_ex_v));
      if (m_ex_v) chk("ex_wr_idx", int'(ex_wr_idx), m_ex_idx);
      chk("wb_wr_en", int'(wb_wr_en), int'(m_wb_wr));
      if (m_wb_wr) chk("wb_wr_idx", int'(wb_wr_idx), m_wb_idx);
      chk("stall_cnt", int'(stall_cnt), m_cnt);
   endtask

   task automatic tick();
      @(posedge clk);
      m_wb_wr  = m_ex_v && m_ex_wr;
      m_wb_idx = m_ex_idx;
      if (id_valid && !last_stall && !flush) begin
         m_ex_v   = 1;
         m_ex_wr  = id_wr_en;
         m_ex_ld  = id_is_load;
         m_ex_idx = int'(id_wr_idx);
      end else begin
         m_ex_v = 0; m_ex_wr = 0; m_ex_ld = 0; m_ex_idx = 0;
      end
      if (stall_cnt_clr)   m_cnt = 0;
      else if (last_stall) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
      @(negedge clk);
   endtask

   task automatic step(input bit v, input bit ae, input int ai,
                       input bit be, input int bi, input bit we,
                       input int wi, input bit ld, input bit fl,
                       input bit clr);
      drive(v, ae, ai, be, bi, we, wi, ld, fl, clr);
      compare();
      tick();
   endtask

   // Enters reset from the negedge phase, checks reset outputs.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_clear();
      chk("rst_ready", int'(id_ready), 1);
      chk("rst_fwd_a", int'(fwd_a_sel), 0);
      chk("rst_fwd_b", int'(fwd_b_sel), 0);
      chk("rst_ex_valid", int'(ex_valid), 0);
      chk("rst_wb_wr_en", int'(wb_wr_en), 0);
      chk("rst_cnt", int'(stall_cnt), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit stalled;
      int k;
      model_clear();
      @(negedge clk);
      do_reset();

      // Back-to-back ALU forward from stage 3.
      step(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
      drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
      compare();
      chk("alu_fwd_a", int'(fwd_a_sel), 1);
      chk("alu_ready", int'(id_ready), 1);
      tick();
      chk("alu_cnt", int'(stall_cnt), 0);

      // Load-use on operand B.
      do_reset();
      step(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
      drive(1, 0, 0, 1, 5, 0, 0, 0, 0, 0);
      compare();
      chk("lu_ready", int'(id_ready), 0);
      tick();
      chk("lu_bubble", int'(ex_valid), 0);
      chk("lu_cnt", int'(stall_cnt), 1);
      drive(1, 0, 0, 1, 5, 0, 0, 0, 0, 0);
      compare();
      if (FWD4) begin
         chk("lu_fwd_b", int'(fwd_b_sel), 2);
         chk("lu_ready2", int'(id_ready), 1);
      end else begin
         chk("lu_fwd_b", int'(fwd_b_sel), 0);
         chk("lu_ready2", int'(id_ready), 0);
      end
      tick();

      // Stage 3 shadows stage 4 on the same register.
      do_reset();
      step(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
      step(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
      drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
      compare();
      chk("prio_fwd_a", int'(fwd_a_sel), 1);
      tick();

      // Flush during a load-use.
      do_reset();
      step(1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
      drive(1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
      compare();
      chk("fl_ready", int'(id_ready), 1);
      tick();
      chk("fl_bubble", int'(ex_valid), 0);
      chk("fl_cnt", int'(stall_cnt), 0);
      chk("fl_wb_en", int'(wb_wr_en), 1);
      chk("fl_wb_idx", int'(wb_wr_idx), 1);

      // Stage-4 match only.
      do_reset();
      step(1, 0, 0, 0, 0, 1, 4, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
      compare();
      chk("wb_ready", int'(id_ready), FWD4 ? 1 : 0);
      chk("wb_fwd_a", int'(fwd_a_sel), FWD4 ? 2 : 0);
      tick();
      drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
      compare();
      chk("wb_fwd_a2", int'(fwd_a_sel), 0);
      chk("wb_ready2", int'(id_ready), 1);
      tick();

      // Reset in the middle of a stall.
      do_reset();
      step(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
      drive(1, 0, 0, 1, 5, 0, 0, 0, 0, 0);
      compare();
      chk("mid_stall", int'(id_ready), 0);
      do_reset();

      // Counter saturation and clear.
      for (int i = 0; i < 300; i++) begin
         step(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
         k = 0;
         do begin
            drive(1, 0, 0, 1, 5, 0, 0, 0, 0, 0);
            compare();
            stalled = last_stall;
            tick();
            k++;
         end while (stalled && k < 4);
         if (stalled) chk("stall_bound", k, 3);
      end
      chk("sat_cnt", int'(stall_cnt), CNT_MAX);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("clr_cnt", int'(stall_cnt), 0);

      // Randomized traffic.
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         step($urandom_range(0, 9) < 8,
              $urandom_range(0, 1), $urandom_range(0, 3),
              $urandom_range(0, 1), $urandom_range(0, 3),
              $urandom_range(0, 9) < 7, $urandom_range(0, 3),
              $urandom_range(0, 9) < 3,
              $urandom_range(0, 19) == 0,
              $urandom_range(0, 29) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
